// File: rtl/mont_pkg.sv
// Shared types and defaults for the Montgomery exponentiation sequencer.
package mont_pkg;

    localparam int unsigned DefaultW = 2048;
    localparam int unsigned DefaultE = 2048;

    typedef logic [DefaultW-1:0] operand_t;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StSqr,
        StMul,
        StFix,
        StDone
    } mexp_state_t;

endpackage

// File: rtl/mont_exp_bitscan.sv
// Latched exponent plus a down-counting bit index, scanned MSB first.
module mont_exp_bitscan #(
    parameter int unsigned E = mont_pkg::DefaultE,
    localparam int unsigned IdxW = (E > 1) ? $clog2(E) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [E-1:0] exp_in,
    input  logic         dec,
    output logic         cur_bit,
    output logic         idx_zero
);

    logic [E-1:0]    exp_q;
    logic [IdxW-1:0] idx_q;

    // Load restarts the scan at the MSB; decrement saturates at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= '0;
            idx_q <= '0;
        end else if (load) begin
            exp_q <= exp_in;
            idx_q <= IdxW'(E - 1);
        end else if (dec && (idx_q != '0)) begin
            idx_q <= idx_q - IdxW'(1);
        end
    end

    assign cur_bit  = exp_q[idx_q];
    assign idx_zero = (idx_q == '0);

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a shared Montgomery multiplier.
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int unsigned W = DefaultW,
    parameter int unsigned E = DefaultE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [W-1:0]                base_m,
    input  logic [W-1:0]                one_m,
    input  logic [E-1:0]                exponent,
    output logic                        busy,
    output logic                        done,
    output logic [W-1:0]                result,
    output logic [$clog2(2*E+2)-1:0]    mul_count,
    output logic                        mm_start,
    output logic [W-1:0]                mm_a,
    output logic [W-1:0]                mm_b,
    input  logic                        mm_done,
    input  logic [W-1:0]                mm_result
);

    localparam int unsigned CntW = $clog2(2*E+2);

    mexp_state_t     state_q, state_d;
    logic            wait_q, wait_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    result_q, result_d;
    logic [W-1:0]    base_q, base_d;
    logic [W-1:0]    one_q, one_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic scan_load, scan_dec, scan_bit, scan_zero;
    logic in_op;

    mont_exp_bitscan #(
        .E(E)
    ) u_bitscan (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (scan_load),
        .exp_in  (exponent),
        .dec     (scan_dec),
        .cur_bit (scan_bit),
        .idx_zero(scan_zero)
    );

    // State and datapath registers; reset aborts any job and forgets outstanding ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wait_q   <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            base_q   <= '0;
            one_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            base_q   <= base_d;
            one_q    <= one_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state, multiplier issue and handshake outputs.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        acc_d     = acc_q;
        result_d  = result_q;
        base_d    = base_q;
        one_d     = one_q;
        cnt_d     = cnt_q;
        scan_load = 1'b0;
        scan_dec  = 1'b0;
        in_op     = 1'b0;
        mm_start  = 1'b0;
        mm_a      = '0;
        mm_b      = '0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    scan_load = 1'b1;
                    base_d    = base_m;
                    one_d     = one_m;
                    cnt_d     = '0;
                    state_d   = StScan;
                end
            end
            StScan: begin
                busy = 1'b1;
                if (scan_bit) begin
                    acc_d = base_q;
                    if (scan_zero) begin
                        state_d = StFix;
                    end else begin
                        scan_dec = 1'b1;
                        state_d  = StSqr;
                    end
                end else if (scan_zero) begin
                    // Exponent is zero: the answer is 1 in Montgomery form.
                    acc_d   = one_q;
                    state_d = StFix;
                end else begin
                    scan_dec = 1'b1;
                end
            end
            StSqr: begin
                busy  = 1'b1;
                in_op = 1'b1;
                mm_a  = acc_q;
                mm_b  = acc_q;
                if (wait_q && mm_done) begin
                    wait_d = 1'b0;
                    acc_d  = mm_result;
                    if (scan_bit) begin
                        state_d = StMul;
                    end else if (scan_zero) begin
                        state_d = StFix;
                    end else begin
                        scan_dec = 1'b1;
                    end
                end
            end
            StMul: begin
                busy  = 1'b1;
                in_op = 1'b1;
                mm_a  = acc_q;
                mm_b  = base_q;
                if (wait_q && mm_done) begin
                    wait_d = 1'b0;
                    acc_d  = mm_result;
                    if (scan_zero) begin
                        state_d = StFix;
                    end else begin
                        scan_dec = 1'b1;
                        state_d  = StSqr;
                    end
                end
            end
            StFix: begin
                // Multiply by plain 1 leaves Montgomery form.
                busy  = 1'b1;
                in_op = 1'b1;
                mm_a  = acc_q;
                mm_b  = W'(1);
                if (wait_q && mm_done) begin
                    wait_d   = 1'b0;
                    result_d = mm_result;
                    state_d  = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Each op state fires exactly one start on entry, then waits for its completion.
        if (in_op && !wait_q) begin
            mm_start = 1'b1;
            wait_d   = 1'b1;
            cnt_d    = cnt_q + CntW'(1);
        end
    end

    assign result    = result_q;
    assign mul_count = cnt_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Scoreboard bench for mont_exp_ctrl with a behavioural Montgomery multiplier (n=13, R=256).
module tb_mont_exp_ctrl;

    localparam int W     = 8;
    localparam int E     = 8;
    localparam int CW    = $clog2(2*E+2);
    localparam int N     = 13;
    localparam int RINV  = 3;   // 256^-1 mod 13
    localparam int ONE_M = 9;   // 256 mod 13

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  base_m = '0;
    logic [W-1:0]  one_m = W'(ONE_M);
    logic [E-1:0]  exponent = '0;
    logic          busy, done;
    logic [W-1:0]  result;
    logic [CW-1:0] mul_count;
    logic          mm_start;
    logic [W-1:0]  mm_a, mm_b;
    logic          mm_done = 1'b0;
    logic [W-1:0]  mm_result = '0;

    mont_exp_ctrl #(
        .W(W),
        .E(E)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_m   (base_m),
        .one_m    (one_m),
        .exponent (exponent),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .mul_count(mul_count),
        .mm_start (mm_start),
        .mm_a     (mm_a),
        .mm_b     (mm_b),
        .mm_done  (mm_done),
        .mm_result(mm_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        int cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   lat = 3;
    bit   job_active = 1'b0;
    bit   pend = 1'b0;
    bit   fresh = 1'b0;
    bit   stale = 1'b0;
    int   a_l = 0, b_l = 0, cnt_l = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Multiplier model: done pulses lat+1 cycles after an accepted mm_start.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            fresh = 1'b0;
            if (mm_done) begin
                mm_done = 1'b0;
                pend    = 1'b0;
                stale   = 1'b0;
            end
            if (pend) begin
                if (cnt_l == 0) begin
                    mm_done   = 1'b1;
                    mm_result = W'((a_l * b_l * RINV) % N);
                end else begin
                    cnt_l--;
                end
            end
            if (mm_start && !pend) begin
                pend  = 1'b1;
                fresh = 1'b1;
                a_l   = int'(mm_a);
                b_l   = int'(mm_b);
                cnt_l = lat;
            end
        end
    end

    // Scoreboard monitor: every done pops one expected job.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_without_job actual=done required=no_done at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", int'(result), e.res);
                chk("mul_count", int'(mul_count), e.cnt);
                job_active = 1'b0;
            end
        end
    end

    // Protocol checker: operands stable and no new start while an op is outstanding.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pend && !stale) begin
                if (!fresh) chk("mm_start_while_wait", int'(mm_start), 0);
                chk("mm_a_stable", int'(mm_a), a_l);
                chk("mm_b_stable", int'(mm_b), b_l);
            end
            if (!job_active) chk("busy_when_idle", int'(busy), 0);
        end
    end

    task automatic run_job(input int bm, input int e, input int l);
        exp_t x;
        int   b, r, bl, pc;
        lat = l;
        b   = (bm * RINV) % N;
        r   = 1;
        for (int i = 0; i < e; i++) r = (r * b) % N;
        bl = 0;
        pc = 0;
        for (int i = 0; i < E; i++) begin
            if (e[i]) begin
                pc++;
                bl = i + 1;
            end
        end
        x.res = r;
        x.cnt = (e == 0) ? 1 : (bl + pc - 1);
        base_m   = W'(bm);
        exponent = E'(e);
        start    = 1'b1;
        sb_q.push_back(x);
        job_active = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_rise", int'(busy), 1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (job_active && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (job_active) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done at %0t", $time);
            job_active = 1'b0;
            sb_q.delete();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_mul_count", int'(mul_count), 0);
        chk("rst_mm_start", int'(mm_start), 0);
        chk("rst_mm_a", int'(mm_a), 0);
        chk("rst_mm_b", int'(mm_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed jobs.
        run_job(5, 5, 3);   wait_done(2000);
        run_job(5, 0, 3);   wait_done(2000);
        run_job(5, 1, 3);   wait_done(2000);
        run_job(5, 255, 3); wait_done(2000);
        run_job(5, 255, 0); wait_done(2000);
        run_job(5, 255, 7); wait_done(2000);

        // Start during SQR is ignored; back-to-back start right after done is accepted.
        run_job(5, 5, 3);
        n = 0;
        while (!mm_start && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first_sqr_seen", int'(mm_start), 1);
        base_m   = W'(7);
        exponent = E'(8'hff);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2000);
        run_job(7, 3, 1);
        wait_done(2000);

        // Reset during MUL with an op outstanding, then a stale completion.
        run_job(5, 5, 3);
        n = 0;
        while (n < 3) begin
            @(posedge clk);
            #1;
            if (mm_start) n++;
        end
        @(posedge clk);
        #2;
        stale = pend;
        rst_n = 1'b0;
        job_active = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_mm_start", int'(mm_start), 0);
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_busy", int'(busy), 0);
        end
        chk("post_rst_result", int'(result), 0);
        chk("post_rst_mul_count", int'(mul_count), 0);
        chk("stale_done_delivered", int'(pend), 0);

        // Randomized jobs.
        for (int i = 0; i < 25; i++) begin
            run_job(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 7)));
            wait_done(2000);
        end

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
